// File: rtl/ecg_window_streamer_if.sv
// -----------------------------------------------------------------------------
// ecg_window_streamer_if
//   Valid/ready sample stream carrying raw ECG samples from the front end
//   (ADC/DMA) into the window streamer.
//
//   Signals:
//     data   SAMPLE_W  sample value, stable while valid is high and not taken
//     valid  1         producer offers a sample
//     ready  1         consumer takes the sample on a cycle with valid high
//
//   Modports:
//     master  producer side (drives data/valid, observes ready)
//     slave   consumer side (observes data/valid, drives ready)
// -----------------------------------------------------------------------------
interface ecg_window_streamer_if #(
    parameter int SAMPLE_W = 16
);
    logic [SAMPLE_W-1:0] data;
    logic                valid;
    logic                ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/ecg_window_streamer.sv
// -----------------------------------------------------------------------------
// ecg_window_streamer
//   Input-side producer for the binary ECG classifier chain. Collects one
//   window of WIN_LEN samples from the upstream stream, holds the accelerator
//   in reset for ARM_CYC cycles, releases it and serves the buffered samples
//   on a pull handshake, then waits for the class result (or a timeout) and
//   reports it with a one-cycle strobe.
//
//   Ports:
//     clk           single clock, rising edge
//     rst           synchronous active-high reset
//     s_if          upstream sample stream (slave side: data/valid in, ready out)
//     acc_rst_n     accelerator run enable (0 = chain held in reset)
//     acc_req       accelerator requests the next sample
//     acc_data      sample to the accelerator, holds value when acc_val is 0
//     acc_val       one-cycle pulse qualifying acc_data
//     acc_done      accelerator class valid pulse
//     acc_class     accelerator class value
//     result        last captured class
//     result_valid  one-cycle result strobe
//     result_err    qualifies result_valid, 1 = timeout without a class
//     busy          high in every state other than FILL
//
//   Every output is a flop. Output flops are loaded from the next-state
//   decode, so a state change and its output levels become visible on the
//   same clock edge.
// -----------------------------------------------------------------------------
module ecg_window_streamer #(
    parameter int SAMPLE_W = 16,
    parameter int WIN_LEN  = 256,
    parameter int ADDR_W   = 8,
    parameter int ARM_CYC  = 4,
    parameter int TIMEOUT  = 65535
) (
    input  logic                clk,
    input  logic                rst,
    ecg_window_streamer_if.slave s_if,
    output logic                acc_rst_n,
    input  logic                acc_req,
    output logic [SAMPLE_W-1:0] acc_data,
    output logic                acc_val,
    input  logic                acc_done,
    input  logic [2:0]          acc_class,
    output logic [2:0]          result,
    output logic                result_valid,
    output logic                result_err,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_ARM    = 2'd1,
        ST_STREAM = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    // Terminal counts. The wait counter starts at 0 on WAIT entry, so the
    // TIMEOUT-th WAIT cycle is the one where it holds TIMEOUT-1.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIN_LEN - 1);
    localparam logic [7:0]        ARM_LAST  = 8'(ARM_CYC - 1);
    localparam logic [15:0]       WAIT_LAST = 16'(TIMEOUT - 1);

    // Window buffer
    logic [SAMPLE_W-1:0] mem_q [WIN_LEN];

    // FSM and counters
    state_t              state_q,    state_d;
    logic [ADDR_W-1:0]   wr_cnt_q,   wr_cnt_d;
    logic [ADDR_W-1:0]   rd_cnt_q,   rd_cnt_d;
    logic [7:0]          arm_cnt_q,  arm_cnt_d;
    logic [15:0]         wait_cnt_q, wait_cnt_d;

    // Registered outputs
    logic                s_ready_q,      s_ready_d;
    logic                acc_rst_n_q,    acc_rst_n_d;
    logic                acc_val_q,      acc_val_d;
    logic [SAMPLE_W-1:0] acc_data_q,     acc_data_d;
    logic [2:0]          result_q,       result_d;
    logic                result_valid_q, result_valid_d;
    logic                result_err_q,   result_err_d;
    logic                busy_q,         busy_d;

    // Buffer write strobe
    logic                wr_en_s;

    // Buffer write port. Contents are not reset: a reset restarts wr_cnt at 0,
    // so stale entries are overwritten before they can ever be read.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_cnt_q] <= s_if.data;
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        state_d        = state_q;
        wr_cnt_d       = wr_cnt_q;
        rd_cnt_d       = rd_cnt_q;
        arm_cnt_d      = arm_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        wr_en_s        = 1'b0;
        acc_val_d      = 1'b0;
        acc_data_d     = acc_data_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        result_err_d   = 1'b0;

        case (state_q)
            ST_FILL: begin
                // Handshake uses the registered ready so the accepted count
                // matches exactly what upstream saw.
                if (s_if.valid && s_ready_q) begin
                    wr_en_s = 1'b1;
                    if (wr_cnt_q == LAST_ADDR) begin
                        wr_cnt_d  = {ADDR_W{1'b0}};
                        arm_cnt_d = 8'd0;
                        state_d   = ST_ARM;
                    end else begin
                        wr_cnt_d  = wr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end

            ST_ARM: begin
                if (arm_cnt_q == ARM_LAST) begin
                    arm_cnt_d = 8'd0;
                    rd_cnt_d  = {ADDR_W{1'b0}};
                    state_d   = ST_STREAM;
                end else begin
                    arm_cnt_d = arm_cnt_q + 8'd1;
                end
            end

            ST_STREAM: begin
                // A request is answered on the following cycle; back-to-back
                // requests give one sample per cycle.
                if (acc_req) begin
                    acc_val_d  = 1'b1;
                    acc_data_d = mem_q[rd_cnt_q];
                    if (rd_cnt_q == LAST_ADDR) begin
                        rd_cnt_d   = {ADDR_W{1'b0}};
                        wait_cnt_d = 16'd0;
                        state_d    = ST_WAIT;
                    end else begin
                        rd_cnt_d   = rd_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    acc_val_d = 1'b0;
                end
            end

            ST_WAIT: begin
                // acc_done has priority over a timeout landing on the same cycle.
                if (acc_done) begin
                    result_d       = acc_class;
                    result_valid_d = 1'b1;
                    result_err_d   = 1'b0;
                    wait_cnt_d     = 16'd0;
                    state_d        = ST_FILL;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    result_valid_d = 1'b1;
                    result_err_d   = 1'b1;
                    wait_cnt_d     = 16'd0;
                    state_d        = ST_FILL;
                end else begin
                    wait_cnt_d     = wait_cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase

        // Level outputs follow the state being entered.
        s_ready_d   = (state_d == ST_FILL);
        acc_rst_n_d = (state_d == ST_STREAM) || (state_d == ST_WAIT);
        busy_d      = (state_d != ST_FILL);
    end

    // State, counter and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_FILL;
            wr_cnt_q       <= {ADDR_W{1'b0}};
            rd_cnt_q       <= {ADDR_W{1'b0}};
            arm_cnt_q      <= 8'd0;
            wait_cnt_q     <= 16'd0;
            s_ready_q      <= 1'b0;
            acc_rst_n_q    <= 1'b0;
            acc_val_q      <= 1'b0;
            acc_data_q     <= {SAMPLE_W{1'b0}};
            result_q       <= 3'd0;
            result_valid_q <= 1'b0;
            result_err_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_cnt_q       <= wr_cnt_d;
            rd_cnt_q       <= rd_cnt_d;
            arm_cnt_q      <= arm_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            s_ready_q      <= s_ready_d;
            acc_rst_n_q    <= acc_rst_n_d;
            acc_val_q      <= acc_val_d;
            acc_data_q     <= acc_data_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            result_err_q   <= result_err_d;
            busy_q         <= busy_d;
        end
    end

    assign s_if.ready   = s_ready_q;
    assign acc_rst_n    = acc_rst_n_q;
    assign acc_val      = acc_val_q;
    assign acc_data     = acc_data_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign result_err   = result_err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ecg_window_streamer.sv
// -----------------------------------------------------------------------------
// tb_ecg_window_streamer
//   Directed + randomized bench for ecg_window_streamer (TIMEOUT shortened to
//   100). A window-level reference model (sample queue plus fill/arm/serve
//   counts) predicts acc_val and acc_data on every cycle.
// -----------------------------------------------------------------------------
module tb_ecg_window_streamer;

    localparam int SAMPLE_W = 16;
    localparam int WIN_LEN  = 256;
    localparam int ADDR_W   = 8;
    localparam int ARM_CYC  = 4;
    localparam int TIMEOUT  = 100;

    logic                clk = 1'b0;
    logic                rst;
    logic                acc_rst_n;
    logic                acc_req;
    logic [SAMPLE_W-1:0] acc_data;
    logic                acc_val;
    logic                acc_done;
    logic [2:0]          acc_class;
    logic [2:0]          result;
    logic                result_valid;
    logic                result_err;
    logic                busy;

    ecg_window_streamer_if #(.SAMPLE_W(SAMPLE_W)) s_if ();

    ecg_window_streamer #(
        .SAMPLE_W (SAMPLE_W),
        .WIN_LEN  (WIN_LEN),
        .ADDR_W   (ADDR_W),
        .ARM_CYC  (ARM_CYC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_if         (s_if),
        .acc_rst_n    (acc_rst_n),
        .acc_req      (acc_req),
        .acc_data     (acc_data),
        .acc_val      (acc_val),
        .acc_done     (acc_done),
        .acc_class    (acc_class),
        .result       (result),
        .result_valid (result_valid),
        .result_err   (result_err),
        .busy         (busy)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: samples of the current window not yet served, how many
    // were accepted into the window, arm cycles left, samples left to serve.
    logic [SAMPLE_W-1:0] win_q [$];
    int                  m_fill = 0;
    int                  m_arm  = 0;
    int                  m_left = 0;
    logic [SAMPLE_W-1:0] m_last_data = '0;
    int                  n_val  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: update the model from the inputs in force before the edge,
    // then check acc_val/acc_data just after the edge.
    task automatic tick();
        logic exp_val;
        exp_val = 1'b0;
        if (rst) begin
            win_q.delete();
            m_fill      = 0;
            m_arm       = 0;
            m_left      = 0;
            m_last_data = '0;
        end else begin
            if (m_left > 0 && acc_req) begin
                exp_val = 1'b1;
                m_left--;
                if (win_q.size() > 0) m_last_data = win_q.pop_front();
            end
            if (m_arm > 0) begin
                m_arm--;
                if (m_arm == 0) m_left = WIN_LEN;
            end
            if (s_if.valid && s_if.ready) begin
                win_q.push_back(s_if.data);
                m_fill++;
                if (m_fill == WIN_LEN) begin
                    m_fill = 0;
                    m_arm  = ARM_CYC;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("acc_val", acc_val, exp_val);
        chk("acc_data", acc_data, m_last_data);
        if (acc_val) n_val++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_ready"},      s_if.ready,   0);
        chk({tag, "_acc_rst_n"},    acc_rst_n,    0);
        chk({tag, "_acc_val"},      acc_val,      0);
        chk({tag, "_acc_data"},     acc_data,     0);
        chk({tag, "_result"},       result,       0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_result_err"},   result_err,   0);
        chk({tag, "_busy"},         busy,         0);
    endtask

    // Fill one window with random valid gaps, honouring valid/ready.
    task automatic fill_random(input int gap_pct);
        int c;
        c = 0;
        s_if.valid = 1'b0;
        while (win_q.size() < WIN_LEN && c < 5000) begin
            if (!s_if.valid) begin
                s_if.valid = ($urandom_range(0, 99) >= gap_pct);
                if (s_if.valid) s_if.data = SAMPLE_W'($urandom);
            end
            tick();
            c++;
            // Sample taken once the model's queue grew past it
            if (s_if.valid && win_q.size() > 0 && win_q[win_q.size()-1] === s_if.data && m_arm > 0 || s_if.valid && m_fill > 0 && win_q.size() == m_fill && win_q[win_q.size()-1] === s_if.data) begin
                s_if.valid = 1'b0;
            end
        end
        s_if.valid = 1'b0;
        chk("fill_bound", c < 5000, 1);
    endtask

    // Serve the whole window with random request gaps.
    task automatic stream_random(input int req_pct);
        int c;
        int v0;
        c  = 0;
        v0 = n_val;
        while ((m_arm > 0 || m_left > 0) && c < 5000) begin
            acc_req = ($urandom_range(0, 99) < req_pct);
            tick();
            c++;
        end
        acc_req = 1'b0;
        chk("stream_bound", c < 5000, 1);
        chk("stream_count", n_val - v0, WIN_LEN);
        chk("stream_queue_empty", win_q.size(), 0);
    endtask

    initial begin
        int cyc;
        int ready_cnt;
        int low_cnt;
        int wcnt;
        int v0;
        bit seen;

        rst        = 1'b1;
        s_if.valid = 1'b0;
        s_if.data  = '0;
        acc_req    = 1'b0;
        acc_done   = 1'b0;
        acc_class  = 3'd0;

        // ---- Reset state
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        // ---- Fill 0..255 with valid held high
        s_if.valid = 1'b1;
        s_if.data  = '0;
        ready_cnt  = 0;
        seen       = 1'b0;
        cyc        = 0;
        while (cyc < 600 && !(seen && !s_if.ready)) begin
            tick();
            cyc++;
            if (s_if.ready) begin
                ready_cnt++;
                seen = 1'b1;
            end
            s_if.data = SAMPLE_W'(win_q.size());
        end
        chk("fill_ready_cycles", ready_cnt, WIN_LEN);
        chk("arm_busy", busy, 1);

        // ---- ARM: valid still high but nothing may be consumed
        low_cnt = 0;
        cyc     = 0;
        while (!acc_rst_n && cyc < 50) begin
            low_cnt++;
            tick();
            cyc++;
        end
        chk("arm_low_cycles", low_cnt, ARM_CYC);
        chk("arm_no_accept", win_q.size(), WIN_LEN);
        chk("stream_s_ready", s_if.ready, 0);
        s_if.valid = 1'b0;

        // ---- STREAM: 256 back-to-back requests, acc_done mid-stream ignored
        acc_req = 1'b1;
        for (int i = 0; i < WIN_LEN; i++) begin
            acc_done  = (i == 100);
            acc_class = (i == 100) ? 3'd7 : 3'd0;
            tick();
            chk("stream_seq", acc_data, i);
            if (i == 100) chk("done_in_stream_ignored", result_valid, 0);
        end
        acc_done  = 1'b0;
        acc_class = 3'd0;
        chk("stream_full_count", n_val, WIN_LEN);
        // Extra requests in WAIT must give no acc_val (checked inside tick)
        repeat (3) tick();
        acc_req = 1'b0;
        chk("wait_no_result_yet", result_valid, 0);

        // ---- WAIT: class 5 captured
        acc_done  = 1'b1;
        acc_class = 3'd5;
        tick();
        acc_done  = 1'b0;
        acc_class = 3'd0;
        chk("done_result", result, 5);
        chk("done_valid", result_valid, 1);
        chk("done_err", result_err, 0);
        chk("done_s_ready", s_if.ready, 1);
        chk("done_acc_rst_n", acc_rst_n, 0);
        chk("done_busy", busy, 0);
        tick();
        chk("done_strobe_one_cycle", result_valid, 0);

        // ---- Random window, then timeout with no acc_done
        fill_random(40);
        stream_random(60);
        wcnt = 0;
        while (!result_valid && wcnt < 300) begin
            acc_req = $urandom_range(0, 1);
            tick();
            wcnt++;
        end
        acc_req = 1'b0;
        chk("timeout_cycles", wcnt, TIMEOUT);
        chk("timeout_err", result_err, 1);
        chk("timeout_result_kept", result, 5);
        tick();
        chk("timeout_strobe_one_cycle", result_valid, 0);

        // ---- Reset mid-STREAM after 37 samples
        fill_random(30);
        v0      = n_val;
        cyc     = 0;
        acc_req = 1'b1;
        while (n_val - v0 < 37 && cyc < 1000) begin
            tick();
            cyc++;
        end
        acc_req = 1'b0;
        chk("partial_stream_count", n_val - v0, 37);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b0;

        // Fresh window streams from its own first sample
        fill_random(50);
        stream_random(50);
        acc_done  = 1'b1;
        acc_class = 3'd2;
        tick();
        acc_done  = 1'b0;
        acc_class = 3'd0;
        chk("fresh_result", result, 2);
        chk("fresh_valid", result_valid, 1);
        chk("fresh_err", result_err, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
